shift_add_mac: RTL and testbench
================================

# shift_add_mac

Iterative shift-and-add multiply-accumulate unit computing p = a*b + c over one operand bit per clock, with valid/ready handshakes on input and output. Generalises the fixed 2-bit gate-level product/carry logic used in our CAD test cases into a WIDTH-parametrised sequential datapath. It serves as a sequential equivalence-checking and ECO benchmark, and as a reusable arithmetic leaf.

## Interface
- WIDTH, default 4: operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  unit can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- c  input  WIDTH  addend.
- out_valid  output  1  result p is valid.
- out_ready  input  1  consumer accepts p.
- p  output  2*WIDTH  result a*b + c.
- busy  output  1  high while in BUSY state.

One clock; reset is asynchronous and active-low.

## Operation
- FSM has three states: IDLE, BUSY and DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture a, b and a bit counter cnt=0.
  - Initialise accumulator acc = c, zero-extended to 2*WIDTH (sign-extended in signed mode).
  - Go to BUSY.
- BUSY:
  - Each edge: if b[cnt]=1, acc = acc + (a << cnt), truncated to 2*WIDTH; then cnt = cnt+1.
  - After the edge processing cnt=WIDTH-1, go to DONE.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1 and p=acc, both held stable until out_ready=1.
  - On an edge with out_ready=1, go to IDLE.
  - in_ready=0 in this state; a new operand set is accepted only from IDLE.
- Width rule (unsigned): max (2^W-1)^2 + (2^W-1) = 2^2W - 2^W, so the result never overflows 2*WIDTH bits.
- busy = (state==BUSY). out_valid = (state==DONE). in_ready = (state==IDLE). All three are state decodes with no combinational path from the inputs.
- p is registered. It holds its last value outside DONE, and is zero after reset.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, p=0.
- Input handshake completes on edge k. busy is high after edges k .. k+WIDTH-1. out_valid is high after edge k+WIDTH.
- Latency from accept to out_valid is WIDTH+1 cycles.
- With out_ready held at 1, throughput is one result per WIDTH+2 cycles.
- out_ready=0 in DONE stalls indefinitely; p must not change while stalled.
- Asserting rst_n low at any point, including mid-BUSY or in DONE, immediately forces IDLE and the reset values. The partial result is discarded and no out_valid is produced for it.
- Inputs a, b and c may change freely after capture without affecting the result.

## Configuration
- SHIFT_ADD_MAC_SIGNED_EN defined:
  - a, b, c and p are two's complement.
  - a and c are sign-extended to 2*WIDTH.
  - The partial product for bit WIDTH-1 of b is subtracted, not added.
  - Result range fits 2*WIDTH signed bits: max 2^(2W-2) + 2^(W-1) - 1, min -2^(2W-2).
  - Timing is unchanged.
- Not defined: unsigned operation as described above.

## Test plan
- WIDTH=4, unsigned. a=15, b=15, c=15 → out_valid exactly 5 cycles after accept, p=240 (0xF0). busy is high for 4 cycles.
- WIDTH=4. a=0, b=9, c=6 → p=6. Then a=11, b=0, c=0 → p=0. in_ready stays low from accept through DONE.
- Back-pressure: a=3, b=5, c=1 with out_ready=0 for 10 cycles → p=16 held stable with out_valid=1. Further in_valid pulses are ignored. Raising out_ready completes the transfer and in_ready returns to 1 on the next cycle.
- Reset mid-operation: assert rst_n low 2 cycles after accepting a=7, b=7, c=0 → immediately out_valid=0, busy=0, in_ready=1, p=0. No stale result appears after reset release.
- SHIFT_ADD_MAC_SIGNED_EN, WIDTH=4:
  - a=-8, b=-8, c=7 → p=71 (0x47).
  - a=-8, b=7, c=-8 → p=-64 (0xC0).
  - a=5, b=-1, c=0 → p=-5 (0xFB).
- Randomised sweep of 1000 operand sets with random in_valid and out_ready stalls, checked against a reference model for WIDTH=2, 4 and 8, in both macro settings.

Source files
------------

// File: rtl/shift_add_mac.sv
// ---------------------------------------------------------------------------
// shift_add_mac
//
// Iterative shift-and-add multiply-accumulate: p = a*b + c, one multiplier
// bit per clock.  A WIDTH-parametrised sequential version of the 2-bit
// product/carry logic, usable as an arithmetic leaf.
//
// Build option:
//   SHIFT_ADD_MAC_SIGNED_EN  - when defined, a, b, c and p are two's
//                              complement; otherwise all are unsigned.
//
// Parameters:
//   WIDTH      operand width, 2..32 (default 4)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand set offered            (input handshake)
//   in_ready   unit can accept operands       (high only in IDLE)
//   a, b, c    multiplicand, multiplier, addend (WIDTH bits)
//   out_valid  p is valid                     (high only in DONE)
//   out_ready  consumer accepts p             (output handshake)
//   p          registered result, 2*WIDTH bits
//   busy       high while in BUSY
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high.  in_ready and out_valid are pure decodes of the registered
// state, so neither depends combinationally on in_valid/out_ready.  Once
// out_valid is high, p is held stable until the transfer completes.
// ---------------------------------------------------------------------------
module shift_add_mac #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     c,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p,
  output logic                 busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   a_sh;    // a extended to PW bits, pre-shifted by cnt
  logic [WIDTH-1:0] b_sh;   // b shifted right so the current bit is b_sh[0]
  logic [PW-1:0]   acc_next;

  // Widen an operand to the accumulator width.
  function automatic logic [PW-1:0] extend(input logic [WIDTH-1:0] v);
`ifdef SHIFT_ADD_MAC_SIGNED_EN
    return {{WIDTH{v[WIDTH-1]}}, v};
`else
    return {{WIDTH{1'b0}}, v};
`endif
  endfunction

  // One accumulate step.  In signed mode the top multiplier bit carries
  // weight -2^(WIDTH-1), so its partial product is subtracted.
  always_comb begin
    acc_next = acc;
    if (b_sh[0]) begin
`ifdef SHIFT_ADD_MAC_SIGNED_EN
      if (cnt == LAST_BIT) acc_next = acc - a_sh;
      else                 acc_next = acc + a_sh;
`else
      acc_next = acc + a_sh;
`endif
    end
  end

  // Status outputs are registered alongside the state so they always match
  // a decode of it: in_ready=IDLE, busy=BUSY, out_valid=DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      p         <= '0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            acc      <= extend(c);
            a_sh     <= extend(a);
            b_sh     <= b;
            cnt      <= '0;
            state    <= S_BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        S_BUSY: begin
          acc  <= acc_next;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // Final bit: publish the finished sum directly into p.
            p         <= acc_next;
            state     <= S_DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mac.sv
// ---------------------------------------------------------------------------
// tb_shift_add_mac
//
// Self-checking bench for shift_add_mac (WIDTH=4).  Directed cases cover
// reset values, handshake timing, back-pressure and mid-operation reset; a
// randomised sweep with random gaps and out_ready stalls is scored against
// an arithmetic reference model through an expected-value queue.
// Honours SHIFT_ADD_MAC_SIGNED_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_shift_add_mac;

  localparam int W  = 4;
  localparam int PW = 2 * W;
  localparam int N_RANDOM = 1000;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [W-1:0]  c;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] p;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PW-1:0] exp_q[$];

  shift_add_mac #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Plain integer arithmetic on the operand values, truncated to 2*W bits.
  function automatic logic [PW-1:0] ref_mac(input logic [W-1:0] x,
                                            input logic [W-1:0] y,
                                            input logic [W-1:0] z);
    longint sx, sy, sz, r;
    sx = longint'(x);
    sy = longint'(y);
    sz = longint'(z);
`ifdef SHIFT_ADD_MAC_SIGNED_EN
    if (x[W-1]) sx = sx - (longint'(1) << W);
    if (y[W-1]) sy = sy - (longint'(1) << W);
    if (z[W-1]) sz = sz - (longint'(1) << W);
`endif
    r = sx * sy + sz;
    return r[PW-1:0];
  endfunction

  // ---------------- driver: one directed operation ----------------
  // Accepts on edge k, checks busy after edges k..k+W-1 and out_valid/p
  // after edge k+W, optionally stalls 'hold' cycles with stray in_valid
  // pulses, then completes the output transfer.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic [W-1:0] tc, input logic [PW-1:0] exp,
                        input string tag, input int hold);
    int busy_cycles;
    int stall_bad;
    busy_cycles = 0;
    stall_bad   = 0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1;
    a = ta; b = tb_; c = tc;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
    for (int i = 0; i < W; i++) begin
      if (busy && !out_valid && !in_ready) busy_cycles++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, busy_cycles, W);
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_in_ready_done"}, in_ready, 0);
    check({tag, "_p"}, p, exp);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      @(posedge clk); #1;
      if (!(out_valid && !in_ready && !busy && p == exp)) stall_bad++;
    end
    in_valid = 1'b0;
    if (hold > 0) check({tag, "_stall_stable"}, stall_bad, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_back"}, in_ready, 1);
    check({tag, "_out_valid_clear"}, out_valid, 0);
    check({tag, "_p_hold"}, p, exp);
  endtask

  // ---------------- random sweep: producer ----------------
  task automatic produce(input int n);
    logic [W-1:0] ra, rb, rc;
    int guard;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      @(negedge clk);
      ra = W'($urandom); rb = W'($urandom); rc = W'($urandom);
      in_valid = 1'b1;
      a = ra; b = rb; c = rc;
      guard = 0;
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 200) begin
        check("rand_accept_timeout", guard, 0);
        in_valid = 1'b0;
        return;
      end
      exp_q.push_back(ref_mac(ra, rb, rc));
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
    end
  endtask

  // ---------------- random sweep: consumer / scoreboard ----------------
  task automatic consume(input int n);
    int got;
    int cycles;
    logic [PW-1:0] e;
    got = 0;
    cycles = 0;
    while (got < n && cycles < 60000) begin
      @(negedge clk);
      cycles++;
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", p, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_p", p, e);
        end
        got++;
      end
    end
    if (got < n) check("rand_result_timeout", got, n);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int stale;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; c = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef SHIFT_ADD_MAC_SIGNED_EN
    run_op(4'h8, 4'h8, 4'h7, 8'h47, "s_m8_m8_7", 0);
    run_op(4'h8, 4'h7, 4'h8, 8'hC0, "s_m8_7_m8", 0);
    run_op(4'h5, 4'hF, 4'h0, 8'hFB, "s_5_m1_0", 0);
`else
    run_op(4'hF, 4'hF, 4'hF, 8'hF0, "u_max", 0);
`endif
    run_op(4'h0, 4'h9, 4'h6, 8'h06, "a_zero", 0);
    run_op(4'hB, 4'h0, 4'h0, 8'h00, "b_zero", 0);
    run_op(4'h3, 4'h5, 4'h1, 8'h10, "backpressure", 10);

    // Reset two cycles into an operation.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'h7; b = 4'h7; c = 4'h0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_busy", busy, 0);
    check("midreset_in_ready", in_ready, 1);
    check("midreset_p", p, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (out_valid || busy) stale++;
    end
    out_ready = 1'b0;
    check("midreset_no_stale", stale, 0);

    // Randomised sweep.
    fork
      produce(N_RANDOM);
      consume(N_RANDOM);
    join
    check("rand_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
